// File: rtl/qea_host_sequencer.sv
// Host sequencer for one QEA instance: loads context RAM, initialises the
// state RAM to |0..0>, runs the accelerator, times it, and streams the final
// state vector out over a valid/ready interface.
module qea_host_sequencer #(
  parameter int unsigned PE_NUM_WIDTH     = 2,
  parameter int unsigned PE_NUM           = 4,
  parameter int unsigned STATE_DATA_WIDTH = 64,
  parameter int unsigned STATE_ADDR_WIDTH = 16,
  parameter int unsigned CTX_DATA_WIDTH   = 64,
  parameter int unsigned CTX_ADDR_WIDTH   = 16,
  parameter int unsigned MAX_QBIT_WIDTH   = 6,
  parameter int unsigned NUM_FRAC_BIT     = 30,
  parameter int unsigned RD_LAT           = 1,
  parameter int unsigned CYC_WIDTH        = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_go,
  input  logic [MAX_QBIT_WIDTH-1:0]            i_qbit_num,
  input  logic [CTX_ADDR_WIDTH-1:0]            i_ins_num,
  input  logic                                 s_ctx_valid,
  output logic                                 s_ctx_ready,
  input  logic [CTX_DATA_WIDTH-1:0]            s_ctx_data,
  output logic                                 o_ctx_en,
  output logic                                 o_ctx_wea,
  output logic [CTX_ADDR_WIDTH-1:0]            o_ctx_addr,
  output logic [CTX_DATA_WIDTH-1:0]            o_ctx_data,
  output logic [PE_NUM-1:0]                    o_state_ena,
  output logic [PE_NUM-1:0]                    o_state_wea,
  output logic [STATE_ADDR_WIDTH-1:0]          o_state_addra,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   o_state_dina,
  output logic                                 o_start,
  input  logic                                 i_complete,
  input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]   i_state_dout,
  output logic                                 m_state_valid,
  input  logic                                 m_state_ready,
  output logic [PE_NUM*STATE_DATA_WIDTH-1:0]   m_state_data,
  output logic                                 m_state_last,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_err,
  output logic [CYC_WIDTH-1:0]                 o_exec_cycles
);

  localparam int unsigned SW    = PE_NUM * STATE_DATA_WIDTH;
  localparam int unsigned LAT_W = 2;

  // Amplitude 1.0 in the real half of lane PE_NUM-1 of word 0.
  localparam logic [SW-1:0] INIT_WORD = SW'(1) << (NUM_FRAC_BIT + SW - STATE_DATA_WIDTH / 2);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD_CTX = 4'd1;
  localparam logic [3:0] S_INIT     = 4'd2;
  localparam logic [3:0] S_START    = 4'd3;
  localparam logic [3:0] S_WAIT     = 4'd4;
  localparam logic [3:0] S_RD_ISSUE = 4'd5;
  localparam logic [3:0] S_RD_WAIT  = 4'd6;
  localparam logic [3:0] S_RD_HOLD  = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  logic [3:0]                  r_state, w_next;
  logic [CTX_ADDR_WIDTH-1:0]   r_ctx_cnt, w_ctx_cnt;
  logic [CTX_ADDR_WIDTH-1:0]   r_ins, w_ins;
  logic [STATE_ADDR_WIDTH-1:0] r_word, w_word;
  logic [STATE_ADDR_WIDTH-1:0] r_last, w_last;
  logic [LAT_W-1:0]            r_lat, w_lat;
  logic                        r_wait_first, w_wait_first;

  logic                        r_ctx_ready, w_ctx_ready;
  logic                        r_ctx_en, w_ctx_en;
  logic [CTX_ADDR_WIDTH-1:0]   r_ctx_addr, w_ctx_addr;
  logic [CTX_DATA_WIDTH-1:0]   r_ctx_data, w_ctx_data;
  logic [PE_NUM-1:0]           r_st_ena, r_st_wea;
  logic                        w_st_en, w_st_we;
  logic [STATE_ADDR_WIDTH-1:0] r_st_addr, w_st_addr;
  logic [SW-1:0]               r_st_din, w_st_din;
  logic                        r_start, w_start;
  logic                        r_done, w_done;
  logic                        r_err, w_err;
  logic                        r_busy, w_busy;
  logic [CYC_WIDTH-1:0]        r_exec, w_exec;
  logic                        r_mvalid, w_mvalid;
  logic                        r_mlast, w_mlast;
  logic [SW-1:0]               r_mdata, w_mdata;

  logic                        w_bad_param;
  logic [MAX_QBIT_WIDTH-1:0]   w_shift;
  logic [STATE_ADDR_WIDTH-1:0] w_last_calc;

  // Last state-word address W-1 for the requested qubit count, saturated to the address width.
  always_comb begin
    w_bad_param = (i_qbit_num < MAX_QBIT_WIDTH'(PE_NUM_WIDTH)) || (i_ins_num == '0);
    w_shift     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
    if (w_shift >= MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH)) begin
      w_last_calc = '1;
    end else begin
      w_last_calc = (STATE_ADDR_WIDTH'(1) << w_shift) - STATE_ADDR_WIDTH'(1);
    end
  end

  // Next state and next value of every registered output.
  always_comb begin
    w_next       = r_state;
    w_ctx_cnt    = r_ctx_cnt;
    w_ins        = r_ins;
    w_word       = r_word;
    w_last       = r_last;
    w_lat        = r_lat;
    w_wait_first = r_wait_first;
    w_ctx_ready  = 1'b0;
    w_ctx_en     = 1'b0;
    w_ctx_addr   = r_ctx_addr;
    w_ctx_data   = r_ctx_data;
    w_st_en      = 1'b0;
    w_st_we      = 1'b0;
    w_st_addr    = r_st_addr;
    w_st_din     = r_st_din;
    w_start      = 1'b0;
    w_done       = 1'b0;
    w_err        = r_err;
    w_exec       = r_exec;
    w_mvalid     = r_mvalid;
    w_mlast      = r_mlast;
    w_mdata      = r_mdata;
    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          if (w_bad_param) begin
            w_err  = 1'b1;
            w_done = 1'b1;
          end else begin
            w_err       = 1'b0;
            w_next      = S_LOAD_CTX;
            w_ctx_ready = 1'b1;
            w_ctx_cnt   = '0;
            w_ins       = i_ins_num;
            w_last      = w_last_calc;
          end
        end
      end
      S_LOAD_CTX: begin
        w_ctx_ready = 1'b1;
        if (s_ctx_valid && r_ctx_ready) begin
          w_ctx_en   = 1'b1;
          w_ctx_addr = r_ctx_cnt;
          w_ctx_data = s_ctx_data;
          w_ctx_cnt  = r_ctx_cnt + CTX_ADDR_WIDTH'(1);
          if (r_ctx_cnt == r_ins - CTX_ADDR_WIDTH'(1)) begin
            w_next      = S_INIT;
            w_ctx_ready = 1'b0;
            w_word      = '0;
            w_st_en     = 1'b1;
            w_st_we     = 1'b1;
            w_st_addr   = '0;
            w_st_din    = INIT_WORD;
          end
        end
      end
      S_INIT: begin
        if (r_word == r_last) begin
          w_next  = S_START;
          w_start = 1'b1;
          w_exec  = '0;
        end else begin
          w_word    = r_word + STATE_ADDR_WIDTH'(1);
          w_st_en   = 1'b1;
          w_st_we   = 1'b1;
          w_st_addr = r_word + STATE_ADDR_WIDTH'(1);
          w_st_din  = '0;
        end
      end
      S_START: begin
        w_next       = S_WAIT;
        w_wait_first = 1'b1;
      end
      S_WAIT: begin
        if (r_exec != '1) begin
          w_exec = r_exec + CYC_WIDTH'(1);
        end
        w_wait_first = 1'b0;
        if (!r_wait_first && i_complete) begin
          w_next    = S_RD_ISSUE;
          w_word    = '0;
          w_st_en   = 1'b1;
          w_st_addr = '0;
        end
      end
      S_RD_ISSUE: begin
        w_next = S_RD_WAIT;
        w_lat  = '0;
      end
      S_RD_WAIT: begin
        if (r_lat == LAT_W'(RD_LAT - 1)) begin
          w_next   = S_RD_HOLD;
          w_mvalid = 1'b1;
          w_mdata  = i_state_dout;
          w_mlast  = (r_word == r_last);
        end else begin
          w_lat = r_lat + LAT_W'(1);
        end
      end
      S_RD_HOLD: begin
        if (m_state_ready) begin
          w_mvalid = 1'b0;
          w_mlast  = 1'b0;
          if (r_word == r_last) begin
            w_next = S_DONE;
            w_done = 1'b1;
          end else begin
            w_next    = S_RD_ISSUE;
            w_word    = r_word + STATE_ADDR_WIDTH'(1);
            w_st_en   = 1'b1;
            w_st_addr = r_word + STATE_ADDR_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    w_busy = (w_next != S_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ctx_cnt    <= '0;
      r_ins        <= '0;
      r_word       <= '0;
      r_last       <= '0;
      r_lat        <= '0;
      r_wait_first <= 1'b0;
      r_ctx_ready  <= 1'b0;
      r_ctx_en     <= 1'b0;
      r_ctx_addr   <= '0;
      r_ctx_data   <= '0;
      r_st_ena     <= '0;
      r_st_wea     <= '0;
      r_st_addr    <= '0;
      r_st_din     <= '0;
      r_start      <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_exec       <= '0;
      r_mvalid     <= 1'b0;
      r_mlast      <= 1'b0;
      r_mdata      <= '0;
    end else begin
      r_state      <= w_next;
      r_ctx_cnt    <= w_ctx_cnt;
      r_ins        <= w_ins;
      r_word       <= w_word;
      r_last       <= w_last;
      r_lat        <= w_lat;
      r_wait_first <= w_wait_first;
      r_ctx_ready  <= w_ctx_ready;
      r_ctx_en     <= w_ctx_en;
      r_ctx_addr   <= w_ctx_addr;
      r_ctx_data   <= w_ctx_data;
      r_st_ena     <= {PE_NUM{w_st_en}};
      r_st_wea     <= {PE_NUM{w_st_we}};
      r_st_addr    <= w_st_addr;
      r_st_din     <= w_st_din;
      r_start      <= w_start;
      r_done       <= w_done;
      r_err        <= w_err;
      r_busy       <= w_busy;
      r_exec       <= w_exec;
      r_mvalid     <= w_mvalid;
      r_mlast      <= w_mlast;
      r_mdata      <= w_mdata;
    end
  end

  assign s_ctx_ready   = r_ctx_ready;
  assign o_ctx_en      = r_ctx_en;
  assign o_ctx_wea     = r_ctx_en;
  assign o_ctx_addr    = r_ctx_addr;
  assign o_ctx_data    = r_ctx_data;
  assign o_state_ena   = r_st_ena;
  assign o_state_wea   = r_st_wea;
  assign o_state_addra = r_st_addr;
  assign o_state_dina  = r_st_din;
  assign o_start       = r_start;
  assign m_state_valid = r_mvalid;
  assign m_state_data  = r_mdata;
  assign m_state_last  = r_mlast;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_err         = r_err;
  assign o_exec_cycles = r_exec;

endmodule

// File: tb/tb_qea_host_sequencer.sv
// Scoreboard bench for qea_host_sequencer with RAM and QEA behavioural models.
module tb_qea_host_sequencer;

  localparam int unsigned SW = 256;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_go;
  logic [5:0]      i_qbit_num;
  logic [15:0]     i_ins_num;
  logic            s_ctx_valid;
  logic            s_ctx_ready;
  logic [63:0]     s_ctx_data;
  logic            o_ctx_en, o_ctx_wea;
  logic [15:0]     o_ctx_addr;
  logic [63:0]     o_ctx_data;
  logic [3:0]      o_state_ena, o_state_wea;
  logic [15:0]     o_state_addra;
  logic [SW-1:0]   o_state_dina;
  logic            o_start;
  logic            i_complete;
  logic [SW-1:0]   i_state_dout;
  logic            m_state_valid;
  logic            m_state_ready;
  logic [SW-1:0]   m_state_data;
  logic            m_state_last;
  logic            o_busy, o_done, o_err;
  logic [31:0]     o_exec_cycles;

  qea_host_sequencer dut (
    .clk(clk), .rst(rst), .i_go(i_go), .i_qbit_num(i_qbit_num), .i_ins_num(i_ins_num),
    .s_ctx_valid(s_ctx_valid), .s_ctx_ready(s_ctx_ready), .s_ctx_data(s_ctx_data),
    .o_ctx_en(o_ctx_en), .o_ctx_wea(o_ctx_wea), .o_ctx_addr(o_ctx_addr), .o_ctx_data(o_ctx_data),
    .o_state_ena(o_state_ena), .o_state_wea(o_state_wea), .o_state_addra(o_state_addra),
    .o_state_dina(o_state_dina), .o_start(o_start), .i_complete(i_complete),
    .i_state_dout(i_state_dout), .m_state_valid(m_state_valid), .m_state_ready(m_state_ready),
    .m_state_data(m_state_data), .m_state_last(m_state_last), .o_busy(o_busy),
    .o_done(o_done), .o_err(o_err), .o_exec_cycles(o_exec_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [15:0] addr; logic [63:0] data; } ctx_t;
  typedef struct packed { logic [15:0] addr; logic [SW-1:0] data; } st_t;
  typedef struct packed { logic last; logic [SW-1:0] data; } rb_t;
  typedef struct packed { logic err; logic [31:0] exec; logic [15:0] words; } dn_t;

  ctx_t ctx_q[$];
  st_t  st_q[$];
  rb_t  rb_q[$];
  dn_t  dn_q[$];

  int checks = 0;
  int errors = 0;
  int start_exp = 0;
  int rd_cnt = 0;
  int rd_exp_addr = 0;
  int qea_d = 0;
  int qea_cnt = 0;
  bit qea_on = 0;
  int bp_mode = 0;
  int hold_cnt = 0;
  logic [SW-1:0] res [64];
  logic [SW-1:0] init_word;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Registered state RAM read port, one cycle of latency; returns the QEA result vector.
  always @(posedge clk) begin
    if (o_state_ena != 4'h0 && o_state_wea == 4'h0)
      i_state_dout <= res[o_state_addra[5:0]];
  end

  // QEA model: raises complete qea_d cycles after the start pulse, holds it until done.
  always @(negedge clk) begin
    if (rst) begin
      qea_on = 0; qea_cnt = 0; i_complete = 1'b0;
    end else if (o_done) begin
      qea_on = 0; i_complete = 1'b0;
    end else if (o_start) begin
      qea_on = 1; qea_cnt = 0;
      if (qea_d <= 0) i_complete = 1'b1;
    end else if (qea_on) begin
      qea_cnt++;
      if (qea_cnt >= qea_d) i_complete = 1'b1;
    end
  end

  // Readback sink: drives ready, checks held data under backpressure, pops expected words.
  logic          hv = 1'b0, hr = 1'b0;
  logic [SW-1:0] hd;
  always @(negedge clk) begin
    logic r;
    rb_t  e;
    if (rst) begin
      m_state_ready = 1'b0; hv = 1'b0; hr = 1'b0;
    end else begin
      if (hv && !hr) begin
        check("rb_hold_valid", SW'(m_state_valid), SW'(1));
        check("rb_hold_data", m_state_data, hd);
      end
      case (bp_mode)
        1: r = 1'($urandom_range(0, 1));
        2: if (m_state_valid && hold_cnt < 5) begin r = 1'b0; hold_cnt++; end else r = 1'b1;
        default: r = 1'b1;
      endcase
      m_state_ready = r;
      if (m_state_valid && r) begin
        if (rb_q.size() == 0) fail("rb_extra");
        else begin
          e = rb_q.pop_front();
          check("rb_data", m_state_data, e.data);
          check("rb_last", SW'(m_state_last), SW'(e.last));
        end
      end
      hv = m_state_valid; hr = r; hd = m_state_data;
    end
  end

  // Monitor for RAM writes, reads, start and done.
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    ctx_t c; st_t s; dn_t d;
    if (!rst) begin
      if (o_ctx_en || o_ctx_wea) begin
        check("ctx_strobes", SW'({o_ctx_en, o_ctx_wea}), SW'(2'b11));
        if (ctx_q.size() == 0) fail("ctx_extra");
        else begin
          c = ctx_q.pop_front();
          check("ctx_addr", SW'(o_ctx_addr), SW'(c.addr));
          check("ctx_data", SW'(o_ctx_data), SW'(c.data));
        end
      end
      if (o_state_wea != 4'h0) begin
        check("st_wr_strobes", SW'({o_state_ena, o_state_wea}), SW'(8'hff));
        if (st_q.size() == 0) fail("st_wr_extra");
        else begin
          s = st_q.pop_front();
          check("st_wr_addr", SW'(o_state_addra), SW'(s.addr));
          check("st_wr_data", o_state_dina, s.data);
        end
      end else if (o_state_ena != 4'h0) begin
        check("st_rd_ena", SW'(o_state_ena), SW'(4'hf));
        check("st_rd_addr", SW'(o_state_addra), SW'(rd_exp_addr));
        rd_exp_addr++;
        rd_cnt++;
      end
      if (o_start) begin
        if (start_exp == 0) fail("start_extra");
        else begin
          start_exp--;
          check("start_after_init", SW'(st_q.size()), SW'(0));
          check("start_one_cycle", SW'(prev_start), SW'(0));
        end
      end
      if (o_done) begin
        if (dn_q.size() == 0) fail("done_extra");
        else begin
          d = dn_q.pop_front();
          check("done_err", SW'(o_err), SW'(d.err));
          if (!d.err) begin
            check("exec_cycles", SW'(o_exec_cycles), SW'(d.exec));
            check("rd_count", SW'(rd_cnt), SW'(d.words));
            check("rb_all_seen", SW'(rb_q.size()), SW'(0));
            check("ctx_all_seen", SW'(ctx_q.size()), SW'(0));
          end
        end
      end
    end
    prev_start = o_start;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctx"}, SW'({o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data, s_ctx_ready}), '0);
    check({tag, "_st_ctl"}, SW'({o_state_ena, o_state_wea, o_state_addra}), '0);
    check({tag, "_st_din"}, o_state_dina, '0);
    check({tag, "_m"}, SW'({m_state_valid, m_state_last}), '0);
    check({tag, "_m_data"}, m_state_data, '0);
    check({tag, "_ctl"}, SW'({o_start, o_busy, o_done, o_err, o_exec_cycles}), '0);
  endtask

  // Issues one run: pushes every expected response, pulses go, streams the context words.
  task automatic do_run(input int q, input int n, input int d, input int gap, input int bp);
    int w, k, budget;
    bit bad, tog, present;
    logic [63:0] cd;
    ctx_t c; st_t s; rb_t r; dn_t e;
    bad = (q < 2) || (n == 0);
    w = bad ? 0 : (1 << (q - 2));
    qea_d = d; bp_mode = bp; hold_cnt = 0; rd_cnt = 0; rd_exp_addr = 0;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < 8; j++) res[i][j*32 +: 32] = $urandom;
      s.addr = 16'(i); s.data = (i == 0) ? init_word : '0; st_q.push_back(s);
      r.last = (i == w - 1); r.data = res[i]; rb_q.push_back(r);
    end
    e.err = bad; e.exec = 32'((d < 2) ? 2 : d); e.words = 16'(w);
    dn_q.push_back(e);
    if (!bad) start_exp++;
    @(negedge clk);
    i_go = 1'b1; i_qbit_num = 6'(q); i_ins_num = 16'(n);
    @(negedge clk);
    i_go = 1'b0;
    if (bad) begin
      check("err_busy", SW'(o_busy), SW'(0));
      check("err_flag", SW'(o_err), SW'(1));
      check("err_done_same", SW'(o_done), SW'(1));
    end
    k = 0; tog = 0; budget = 0;
    while (!bad && k < n && budget < 5000) begin
      case (gap)
        0: present = 1;
        1: present = !tog;
        default: present = 1'($urandom_range(0, 1));
      endcase
      tog = !tog;
      cd = {$urandom, $urandom};
      s_ctx_valid = present; s_ctx_data = cd;
      if (present && s_ctx_ready) begin
        c.addr = 16'(k); c.data = cd; ctx_q.push_back(c); k++;
      end
      @(negedge clk);
      budget++;
    end
    s_ctx_valid = 1'b0;
    if (budget >= 5000) fail("ctx_load_timeout");
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (dn_q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 5000) fail("done_timeout");
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc;
    init_word = '0;
    init_word[255:224] = 32'h4000_0000;
    rst = 1'b1; i_go = 1'b0; i_qbit_num = '0; i_ins_num = '0;
    s_ctx_valid = 1'b0; s_ctx_data = '0; i_state_dout = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    do_run(3, 103, 50, 0, 0);
    wait_done();
    do_run(2, 6, 1, 1, 2);
    wait_done();
    do_run(1, 5, 10, 0, 0);
    wait_done();
    repeat (3) @(negedge clk);
    check("err_sticky", SW'(o_err), SW'(1));
    do_run(4, 0, 10, 0, 0);
    wait_done();

    do_run(4, 10, 20, 2, 1);
    i_go = 1'b1; i_qbit_num = 6'd1; i_ins_num = 16'd0;
    @(negedge clk);
    i_go = 1'b0;
    wait_done();

    do_run(4, 8, 30, 0, 0);
    cyc = 0;
    while (!o_start && cyc < 500) begin @(negedge clk); cyc++; end
    if (cyc >= 500) fail("start_timeout");
    repeat (10) @(negedge clk);
    check("wait_busy", SW'(o_busy), SW'(1));
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("abort");
    ctx_q.delete(); st_q.delete(); rb_q.delete(); dn_q.delete(); start_exp = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_run(3, 12, 15, 0, 0);
    wait_done();

    for (int t = 0; t < 5; t++) begin
      do_run($urandom_range(2, 5), $urandom_range(1, 30), $urandom_range(0, 40),
             $urandom_range(0, 2), $urandom_range(0, 2));
      wait_done();
    end
    check("final_idle", SW'({o_busy, m_state_valid, s_ctx_ready}), '0);
    check("final_queues", SW'(ctx_q.size() + st_q.size() + rb_q.size() + start_exp), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/qea_host_sequencer.md
Name: qea_host_sequencer

Overview:
- Hardware host sequencer for the QEA accelerator. It streams gate-context words into the QEA context RAM and initialises the state RAM to |0..0>.
- It then pulses start, waits for complete, measures execution cycles, and reads the final state vector back out as a valid/ready stream.
- It replaces the software load/run/readback sequence and sits between a DMA/stream fabric and one QEA instance.

Parameters:
PE_NUM_WIDTH, 2, log2 of PE lanes per state word
PE_NUM, 4, lanes per state RAM word
STATE_DATA_WIDTH, 64, one complex amplitude per lane (real in upper half, imag in lower half)
STATE_ADDR_WIDTH, 16, state RAM address width
CTX_DATA_WIDTH, 64, context word width
CTX_ADDR_WIDTH, 16, context RAM address width
MAX_QBIT_WIDTH, 6, qubit-count field width
NUM_FRAC_BIT, 30, fixed-point fraction bits; 1.0 = 2^NUM_FRAC_BIT
RD_LAT, 1, state RAM read latency in cycles (1..3)
CYC_WIDTH, 32, execution-cycle counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_go  in  1  one-cycle request to run; accepted only in IDLE
i_qbit_num  in  MAX_QBIT_WIDTH  qubit count, latched on accepted i_go
i_ins_num  in  CTX_ADDR_WIDTH  context words to load, latched on accepted i_go
s_ctx_valid  in  1  context stream valid
s_ctx_ready  out  1  context stream ready
s_ctx_data  in  CTX_DATA_WIDTH  context word
o_ctx_en, o_ctx_wea  out  1  context RAM write strobes
o_ctx_addr  out  CTX_ADDR_WIDTH  context RAM address
o_ctx_data  out  CTX_DATA_WIDTH  context RAM write data
o_state_ena, o_state_wea  out  PE_NUM  per-lane state RAM enable / write enable
o_state_addra  out  STATE_ADDR_WIDTH  state RAM address
o_state_dina  out  PE_NUM*STATE_DATA_WIDTH  state RAM write data
o_start  out  1  QEA start pulse
i_complete  in  1  QEA complete
i_state_dout  in  PE_NUM*STATE_DATA_WIDTH  state RAM read data
m_state_valid  out  1  readback stream valid
m_state_ready  in  1  readback stream ready
m_state_data  out  PE_NUM*STATE_DATA_WIDTH  readback word
m_state_last  out  1  marks the final readback word
o_busy  out  1  high in any state except IDLE
o_done  out  1  one-cycle pulse when the run finishes
o_err  out  1  sticky parameter error; cleared by the next accepted i_go
o_exec_cycles  out  CYC_WIDTH  cycles measured in WAIT

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0. Reset is asynchronous and takes effect in any state; an interrupted run is abandoned with no o_done.
- FSM states: IDLE -> LOAD_CTX -> INIT_STATE -> START -> WAIT -> RD_ISSUE -> RD_WAIT -> RD_HOLD -> (RD_ISSUE | DONE) -> IDLE.
- Word count: W = 2^(qbit_num - PE_NUM_WIDTH).
- IDLE, i_go high:
  - If qbit_num < PE_NUM_WIDTH or ins_num = 0, set o_err = 1, pulse o_done, and stay in IDLE.
  - Otherwise clear o_err and go to LOAD_CTX.
- LOAD_CTX:
  - s_ctx_ready = 1.
  - Each valid&ready beat registers o_ctx_en = o_ctx_wea = 1, o_ctx_addr = k (k = 0..ins_num-1) and o_ctx_data = the beat data, all appearing the next cycle.
  - Cycles without a beat drive en/wea = 0.
  - After beat ins_num-1: s_ctx_ready drops the next cycle and the FSM goes to INIT_STATE.
- INIT_STATE: writes one word per cycle for W cycles, with ena = wea = all ones and addresses 0..W-1.
  - Word 0: bits [PE_NUM*STATE_DATA_WIDTH-1 -: STATE_DATA_WIDTH/2] = 2^NUM_FRAC_BIT (default 0x40000000); all other bits 0.
  - All other words are 0.
- START: o_start = 1 for exactly one cycle; o_exec_cycles is cleared.
- WAIT:
  - o_exec_cycles increments every WAIT cycle and saturates at all ones.
  - i_complete is ignored in the first WAIT cycle and sampled from the second onward.
  - The count includes the cycle in which complete is sampled; the FSM then goes to RD_ISSUE with address 0.
- RD_ISSUE: one cycle with ena = all ones, wea = 0 and the current address.
- RD_WAIT: RD_LAT cycles, then i_state_dout is captured into m_state_data.
- RD_HOLD:
  - m_state_valid = 1, with m_state_last = 1 on address W-1.
  - Data is held stable while m_state_ready = 0.
  - On handshake: if this was the last word go to DONE, otherwise increment the address and go to RD_ISSUE.
- DONE: o_done pulses for one cycle, then IDLE.
- o_exec_cycles holds its value until the next START.
- i_go is ignored while busy. o_ctx_* and o_state_* are registered outputs.

Test Plan:
- qbit_num = 3, ins_num = 103, gap-free ctx stream -> 103 ctx writes at addresses 0..102 on consecutive cycles. Then state writes: addr 0 with bits [255:224] = 0x40000000 and the rest 0; addr 1 = 0. Then one o_start pulse.
- Model QEA raises complete 50 cycles after start -> o_exec_cycles = 50. Two readback words follow, with m_state_last only on word 1, then one o_done pulse.
- Ctx valid toggled 1,0,1,0 -> addresses stay contiguous, and en/wea are low on idle cycles.
- m_state_ready held low for 5 cycles during RD_HOLD -> data and valid stay stable; no extra RAM read is issued.
- qbit_num = 1, or ins_num = 0 -> o_err = 1 and o_done pulses the same cycle. No RAM writes and no o_start; o_busy stays 0.
- rst asserted during WAIT -> all outputs 0 immediately. A following i_go runs a full sequence correctly.
